hvsync_gen: RTL and testbench
=============================

# hvsync_gen

VGA raster timing generator for the 640x480 character terminal. Running on the 25 MHz pixel clock, it produces horizontal and vertical sync, the current raster position and a visible-area flag. The downstream display buffer and font ROM are indexed from these signals. The default horizontal back porch is 2 pixels shorter than standard, which compensates for the 2-cycle synchronous buffer-plus-font read latency downstream.

## Interface
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 46: horizontal back porch, pixels (48 − 2 pipeline compensation)
- V_DISPLAY, 480: visible lines per frame
- V_BOTTOM, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_TOP, 33: vertical back porch, lines
- SYNC_ACTIVE, 1'b1: asserted level of hsync/vsync
- clk  in  1  pixel clock (25 MHz); all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- display_on  out  1  high while the raster is inside the visible area
- hpos  out  10  current pixel column, registered
- vpos  out  10  current line, registered
- line_end  out  1  high when hpos == H_MAX
- frame_end  out  1  high when hpos == H_MAX and vpos == V_MAX

## Operation
- H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK−1 (797 with defaults).
- V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP−1 (524 with defaults).
- hpos increments every clock and wraps from H_MAX to 0.
- vpos increments only when hpos wraps, and wraps from V_MAX to 0 on the same edge.
- H sync window: H_SYNC_START = H_DISPLAY+H_FRONT (656) through H_SYNC_END = H_SYNC_START+H_SYNC−1 (751).
- V sync window: V_SYNC_START = V_DISPLAY+V_BOTTOM (490) through V_SYNC_END = V_SYNC_START+V_SYNC−1 (491).
- hsync is registered: it takes SYNC_ACTIVE on the clock after hpos enters the H sync window, and drives ~SYNC_ACTIVE otherwise.
- vsync is registered the same way from the vpos window.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY). It is combinational from the registered counters.
- line_end and frame_end are combinational decodes of the registered counters.
- All arithmetic is unsigned 10-bit. Any parameter set whose H_MAX or V_MAX exceeds 1023 is unsupported; an elaboration-time check flags it.

## Timing
- Reset values: hpos = 0, vpos = 0, hsync = vsync = ~SYNC_ACTIVE.
- During reset: display_on = 1, line_end = 0, frame_end = 0.
- After reset is released, hpos = 1 on the first clock edge.
- A reset asserted mid-line or mid-frame forces the reset values on the next edge, with no partial-line completion.
- hsync lags hpos by exactly 1 cycle. With SYNC_ACTIVE = 1, hsync is high during the clocks where the registered hpos is 657..752, mod line length.
- vsync lags by 1 clock relative to vpos. It becomes active on the clock after vpos first reads 490, and inactive on the clock after vpos reads 492.
- A line is H_MAX+1 = 798 clocks. A frame is 798 × 525 = 418,950 clocks.
- At the frame wrap, hpos and vpos return to 0 on the same edge.

## Structure
- Shared package `vga_timing_pkg` holds the default 640x480 timing constants (the eight porch/sync/display values plus SYNC_ACTIVE). The display buffer and font ROM logic share its derived H_MAX/V_MAX and char geometry (8x12 cell, 80 columns × 40 row-index range).
- hvsync_gen contains no sub-modules: two counters plus two sync registers, all inline.

## Test plan
- Reset: hold reset for 5 clocks at an arbitrary position -> hpos = 0, vpos = 0, hsync = vsync = 0, display_on = 1, line_end = 0.
- Line wrap: run from reset to hpos = 797 -> line_end = 1. Next clock -> hpos = 0, vpos = 1.
- Hsync window: sample hpos and hsync across line 0 -> hsync is 1 exactly when hpos ∈ [657, 752] and 0 elsewhere. Pulse width is 96 clocks.
- Visible area: sample display_on across one line and across frame boundaries -> falls on the transition hpos 639→640 and rises on 797→0. It is 0 for every hpos when vpos ∈ [480, 524].
- Vsync and frame wrap: run a full frame -> vsync is high for exactly 2 × 798 clocks, starting one clock after vpos becomes 490. frame_end pulses once at (797, 524); the next clock gives (0, 0). The total frame period is 418,950 clocks.
- Mid-frame reset: assert reset for 1 clock at (700, 491) while hsync and vsync are active -> next edge gives (0, 0) with both syncs inactive. Normal counting resumes.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480 raster timing shared by the sync generator, display buffer and font ROM.
// Derived line/frame extents and character-cell geometry live here so every consumer agrees.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    // Two pixels short of the standard 48 to absorb the buffer-plus-font read latency.
    localparam int unsigned H_BACK    = 46;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_BOTTOM  = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_TOP     = 33;
    localparam logic        SYNC_ACTIVE = 1'b1;

    localparam int unsigned H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int unsigned V_MAX = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned CHAR_H    = 12;
    localparam int unsigned CHAR_COLS = 80;
    localparam int unsigned CHAR_ROWS = 40;

    function automatic logic in_window(input logic [9:0] pos,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/hvsync_gen.sv
// VGA raster timing: free-running pixel/line counters with registered syncs.
// Syncs are decoded from the current counters, so they trail the position by one clock.
module hvsync_gen #(
    parameter int unsigned H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_BOTTOM    = vga_timing_pkg::V_BOTTOM,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_TOP       = vga_timing_pkg::V_TOP,
    parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_end,
    output logic       frame_end
);
    import vga_timing_pkg::in_window;

    localparam int unsigned H_MAX_I = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int unsigned V_MAX_I = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    if (H_MAX_I > 1023 || V_MAX_I > 1023) begin : g_range_err
        $error("hvsync_gen: H_MAX or V_MAX exceeds the 10-bit counter range");
    end

    localparam logic [9:0] H_MAX    = 10'(H_MAX_I);
    localparam logic [9:0] V_MAX    = 10'(V_MAX_I);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       h_wrap;

    always_comb begin
        h_wrap  = (hpos_q == H_MAX);
        hpos_d  = h_wrap ? 10'd0 : hpos_q + 10'd1;
        vpos_d  = vpos_q;
        if (h_wrap) begin
            vpos_d = (vpos_q == V_MAX) ? 10'd0 : vpos_q + 10'd1;
        end
        hsync_d = in_window(hpos_q, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = in_window(vpos_q, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= 10'd0;
            vpos_q  <= 10'd0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign line_end   = h_wrap;
    assign frame_end  = h_wrap && (vpos_q == V_MAX);

endmodule

// File: tb/tb_hvsync_gen.sv
// Scoreboard bench for hvsync_gen: default-timing instance plus a short-frame instance
// (13 lines) so full-frame vertical behaviour fits in a short run.
`timescale 1ns/1ps
module tb_hvsync_gen;

    localparam int LINE    = 798;
    localparam int HS_LO   = 656;
    localparam int HS_HI   = 751;
    localparam int H_VIS   = 640;
    localparam int HLAST   = 797;
    localparam int MID_K   = 18256;   // (700, 9) on the short-frame instance

    typedef struct {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic       le;
        logic       fe;
    } obs_t;

    typedef struct {
        int   at;
        int   k;
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t sbq[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   step = 0;
    int   checks = 0;
    int   errors = 0;

    logic       hs_a, vs_a, disp_a, le_a, fe_a;
    logic [9:0] hp_a, vp_a;
    logic       hs_b, vs_b, disp_b, le_b, fe_b;
    logic [9:0] hp_b, vp_b;

    always #20 clk = ~clk;
    always @(posedge clk) step <= step + 1;

    hvsync_gen u_dut_a (
        .clk(clk), .reset(reset), .hsync(hs_a), .vsync(vs_a), .display_on(disp_a),
        .hpos(hp_a), .vpos(vp_a), .line_end(le_a), .frame_end(fe_a)
    );

    hvsync_gen #(.V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)) u_dut_b (
        .clk(clk), .reset(reset), .hsync(hs_b), .vsync(vs_b), .display_on(disp_b),
        .hpos(hp_b), .vpos(vp_b), .line_end(le_b), .frame_end(fe_b)
    );

    // Closed-form position after k clocks since reset release.
    function automatic obs_t model(int k, int vt, int vdisp, int vs_lo, int vs_hi);
        obs_t o;
        int hp, vp, php, pvp;
        hp = k % LINE;
        vp = (k / LINE) % vt;
        o.hpos = 10'(hp);
        o.vpos = 10'(vp);
        o.disp = (hp < H_VIS) && (vp < vdisp);
        o.le   = (hp == HLAST);
        o.fe   = (hp == HLAST) && (vp == vt - 1);
        if (k == 0) begin
            o.hsync = 1'b0;
            o.vsync = 1'b0;
        end else begin
            php = (k - 1) % LINE;
            pvp = ((k - 1) / LINE) % vt;
            o.hsync = (php >= HS_LO) && (php <= HS_HI);
            o.vsync = (pvp >= vs_lo) && (pvp <= vs_hi);
        end
        return o;
    endfunction

    task automatic expect_at(int at, int k);
        exp_t e;
        e.at = at;
        e.k  = k;
        e.a  = model(k, 525, 480, 490, 491);
        e.b  = model(k, 13, 6, 8, 9);
        sbq.push_back(e);
    endtask

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cmp_obs(string who, int k, obs_t act, obs_t req);
        chk($sformatf("%s.hpos@k%0d", who, k), int'(act.hpos), int'(req.hpos));
        chk($sformatf("%s.vpos@k%0d", who, k), int'(act.vpos), int'(req.vpos));
        chk($sformatf("%s.hsync@k%0d", who, k), int'(act.hsync), int'(req.hsync));
        chk($sformatf("%s.vsync@k%0d", who, k), int'(act.vsync), int'(req.vsync));
        chk($sformatf("%s.display_on@k%0d", who, k), int'(act.disp), int'(req.disp));
        chk($sformatf("%s.line_end@k%0d", who, k), int'(act.le), int'(req.le));
        chk($sformatf("%s.frame_end@k%0d", who, k), int'(act.fe), int'(req.fe));
    endtask

    // Aggregates gathered over the first run segment.
    logic seg1 = 1'b0;
    int   rel0 = 0;
    int   hs_cnt_a = 0;
    int   vs_cnt_b = 0;
    int   fe_cnt_b = 0;
    int   fe_k_b = -1;
    int   le_k0 = -1;
    int   le_k1 = -1;
    int   rel_bad = 0;

    always @(negedge clk) begin : monitor
        obs_t ca, cb;
        exp_t e;
        int   kk;
        ca = '{hpos: hp_a, vpos: vp_a, hsync: hs_a, vsync: vs_a, disp: disp_a, le: le_a, fe: fe_a};
        cb = '{hpos: hp_b, vpos: vp_b, hsync: hs_b, vsync: vs_b, disp: disp_b, le: le_b, fe: fe_b};
        while (sbq.size() > 0 && sbq[0].at <= step) begin
            e = sbq.pop_front();
            if (e.at < step) begin
                chk($sformatf("missed_entry@k%0d", e.k), step, e.at);
            end else begin
                cmp_obs("A", e.k, ca, e.a);
                cmp_obs("B", e.k, cb, e.b);
            end
        end
        if (seg1) begin
            kk = step - rel0;
            if (kk <= HLAST && hs_a) hs_cnt_a++;
            if (kk <= 13 * LINE - 1) begin
                if (vs_b) vs_cnt_b++;
                if (fe_b) begin
                    fe_cnt_b++;
                    if (fe_k_b < 0) fe_k_b = kk;
                end
            end
            if (le_a) begin
                if (le_k0 < 0) le_k0 = kk;
                else if (le_k1 < 0) le_k1 = kk;
            end
            if (disp_a != ((hp_a < 10'd640) && (vp_a < 10'd480))) rel_bad++;
            if (disp_b != ((hp_b < 10'd640) && (vp_b < 10'd6))) rel_bad++;
            if (hs_a != ((hp_a >= 10'd657) && (hp_a <= 10'd752))) rel_bad++;
            if (le_a != (hp_a == 10'd797)) rel_bad++;
            if (fe_b != ((hp_b == 10'd797) && (vp_b == 10'd12))) rel_bad++;
        end
    end

    initial begin : stimulus
        int ks1[$];
        int ks2[$];
        int r;
        ks1 = '{0, 1, 2, 639, 640, 655, 656, 657, 658, 751, 752, 753, 796, 797, 798, 799,
                1595, 1596, 4788, 4888, 6384, 6385, 7980, 7981, 10373, 10374, MID_K};
        ks2 = '{1, 2, 656, 657, 753, 798, 6385};

        for (int s = 1; s <= 5; s++) expect_at(s, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        r = step;
        rel0 = r;
        reset = 1'b0;
        seg1 = 1'b1;
        foreach (ks1[i]) expect_at(r + ks1[i], ks1[i]);

        repeat (MID_K) @(posedge clk);
        #1;
        // Both syncs active on instance B here; a one-clock reset must clear everything.
        reset = 1'b1;
        seg1 = 1'b0;
        expect_at(step + 1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        r = step;
        foreach (ks2[i]) expect_at(r + ks2[i], ks2[i]);

        repeat (6500) @(posedge clk);
        repeat (3) @(negedge clk);

        chk("pending_entries", sbq.size(), 0);
        chk("hsync_width_line0", hs_cnt_a, 96);
        chk("vsync_clocks_frame", vs_cnt_b, 2 * LINE);
        chk("frame_end_pulses", fe_cnt_b, 1);
        chk("frame_end_k", fe_k_b, 13 * LINE - 1);
        chk("first_line_end_k", le_k0, HLAST);
        chk("line_period", le_k1 - le_k0, LINE);
        chk("decode_relation_errors", rel_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
